// File: rtl/instr_encoder_loader.sv
// Encodes internal instruction codes into 32-bit MIPS words, queues them in a
// FIFO and streams them to the instruction-memory write port.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   encode request handshake
//   instrCode_in        internal instruction code
//   rs_in .. target_in  operand fields
//   im_we/im_ready      IM write request and acceptance
//   im_addr, im_wdata   byte address and data of the current write
//   words_written       number of completed IM writes (wraps)
//   err                 sticky: an unknown code was accepted
module instr_encoder_loader #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  instrCode_in,
  input  logic [4:0]  rs_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic [4:0]  shamt_in,
  input  logic [15:0] imm_in,
  input  logic [25:0] target_in,
  output logic        im_we,
  input  logic        im_ready,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic [15:0] words_written,
  output logic        err
);

  // Internal instruction codes (shared encoding with the decoder).
  localparam logic [5:0] C_ADDU = 6'd1;
  localparam logic [5:0] C_SUBU = 6'd2;
  localparam logic [5:0] C_ORI  = 6'd3;
  localparam logic [5:0] C_LW   = 6'd4;
  localparam logic [5:0] C_SW   = 6'd5;
  localparam logic [5:0] C_BEQ  = 6'd6;
  localparam logic [5:0] C_LUI  = 6'd7;
  localparam logic [5:0] C_J    = 6'd8;
  localparam logic [5:0] C_JAL  = 6'd9;
  localparam logic [5:0] C_JR   = 6'd10;
  localparam logic [5:0] C_SLL  = 6'd11;
  localparam logic [5:0] C_ANDI = 6'd12;

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] enc;
  logic        known;

  // Unused fields are forced to zero rather than passed through.
  always_comb begin
    enc   = 32'd0;
    known = 1'b1;
    unique case (instrCode_in)
      C_ADDU: enc = {6'b000000, rs_in, rt_in, rd_in,
                     5'b00000, 6'b100001};
      C_SUBU: enc = {6'b000000, rs_in, rt_in, rd_in,
                     5'b00000, 6'b100011};
      C_JR:   enc = {6'b000000, rs_in, 15'd0, 6'b001000};
      C_SLL:  enc = {6'b000000, 5'd0, rt_in, rd_in,
                     shamt_in, 6'b000000};
      C_ORI:  enc = {6'b001101, rs_in, rt_in, imm_in};
      C_ANDI: enc = {6'b001100, rs_in, rt_in, imm_in};
      C_LW:   enc = {6'b100011, rs_in, rt_in, imm_in};
      C_SW:   enc = {6'b101011, rs_in, rt_in, imm_in};
      C_BEQ:  enc = {6'b000100, rs_in, rt_in, imm_in};
      C_LUI:  enc = {6'b001111, 5'd0, rt_in, imm_in};
      C_J:    enc = {6'b000010, target_in};
      C_JAL:  enc = {6'b000011, target_in};
      default: known = 1'b0;
    endcase
  end

  // Extra pointer bit separates full from empty.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // No bypass: a same-cycle pop does not open a full FIFO.
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && known;

  assign im_we    = !empty;
  assign pop      = im_we && im_ready;
  assign im_wdata = empty ? 32'd0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp[AW-1:0]] <= enc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp            <= '0;
      rp            <= '0;
      im_addr       <= BASE_ADDR;
      words_written <= 16'd0;
      err           <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp            <= rp + 1'b1;
        im_addr       <= im_addr + 32'd4;
        words_written <= words_written + 16'd1;
      end
      if (accept && !known) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed scoreboard bench for instr_encoder_loader.
module tb_instr_encoder_loader;

  localparam logic [31:0] BASE = 32'h0000_3000;

  localparam logic [5:0] C_ADDU = 6'd1;
  localparam logic [5:0] C_SUBU = 6'd2;
  localparam logic [5:0] C_ORI  = 6'd3;
  localparam logic [5:0] C_LW   = 6'd4;
  localparam logic [5:0] C_SW   = 6'd5;
  localparam logic [5:0] C_BEQ  = 6'd6;
  localparam logic [5:0] C_LUI  = 6'd7;
  localparam logic [5:0] C_J    = 6'd8;
  localparam logic [5:0] C_JAL  = 6'd9;
  localparam logic [5:0] C_JR   = 6'd10;
  localparam logic [5:0] C_SLL  = 6'd11;
  localparam logic [5:0] C_ANDI = 6'd12;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  instrCode_in;
  logic [4:0]  rs_in;
  logic [4:0]  rt_in;
  logic [4:0]  rd_in;
  logic [4:0]  shamt_in;
  logic [15:0] imm_in;
  logic [25:0] target_in;
  logic        im_we;
  logic        im_ready;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic [15:0] words_written;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] sbq[$];
  logic [31:0] exp_addr;
  logic [15:0] exp_ww;

  instr_encoder_loader #(
    .DEPTH(4),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instrCode_in(instrCode_in),
    .rs_in(rs_in),
    .rt_in(rt_in),
    .rd_in(rd_in),
    .shamt_in(shamt_in),
    .imm_in(imm_in),
    .target_in(target_in),
    .im_we(im_we),
    .im_ready(im_ready),
    .im_addr(im_addr),
    .im_wdata(im_wdata),
    .words_written(words_written),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Reference encoding; bit 32 flags a known code.
  function automatic logic [32:0] model(
    input logic [5:0] c, input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd,
    input logic [4:0] sh, input logic [15:0] imm,
    input logic [25:0] tg);
    case (c)
      C_ADDU: return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h21};
      C_SUBU: return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h23};
      C_JR:   return {1'b1, 6'h00, rs, 15'd0, 6'h08};
      C_SLL:  return {1'b1, 6'h00, 5'd0, rt, rd, sh, 6'h00};
      C_ORI:  return {1'b1, 6'h0D, rs, rt, imm};
      C_ANDI: return {1'b1, 6'h0C, rs, rt, imm};
      C_LW:   return {1'b1, 6'h23, rs, rt, imm};
      C_SW:   return {1'b1, 6'h2B, rs, rt, imm};
      C_BEQ:  return {1'b1, 6'h04, rs, rt, imm};
      C_LUI:  return {1'b1, 6'h0F, 5'd0, rt, imm};
      C_J:    return {1'b1, 6'h02, tg};
      C_JAL:  return {1'b1, 6'h03, tg};
      default: return 33'd0;
    endcase
  endfunction

  task automatic drive(input logic [5:0] c,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic [4:0] rd,
                       input logic [4:0] sh,
                       input logic [15:0] imm,
                       input logic [25:0] tg);
    instrCode_in = c;
    rs_in        = rs;
    rt_in        = rt;
    rd_in        = rd;
    shamt_in     = sh;
    imm_in       = imm;
    target_in    = tg;
    in_valid     = 1'b1;
  endtask

  // Waits (bounded) for acceptance, then records the expected word.
  task automatic commit();
    logic [32:0] m;
    int n;
    m = model(instrCode_in, rs_in, rt_in, rd_in,
              shamt_in, imm_in, target_in);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (m[32]) sbq.push_back(m[31:0]);
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [5:0] c,
                      input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic [4:0] rd,
                      input logic [4:0] sh,
                      input logic [15:0] imm,
                      input logic [25:0] tg);
    drive(c, rs, rt, rd, sh, imm, tg);
    commit();
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (im_we && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_wait", {31'd0, im_we}, 32'd0);
    chk("drain_sbq", sbq.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: compares every completed write with the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      chk("words_written", {16'd0, words_written},
          {16'd0, exp_ww});
      if (im_we && im_ready) begin
        if (sbq.size() == 0) begin
          chk("spurious_write", im_wdata, 32'hxxxx_xxxx);
        end else begin
          chk("im_wdata", im_wdata, sbq.pop_front());
          chk("im_addr", im_addr, exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
        exp_ww   = exp_ww + 16'd1;
      end
    end
  end

  logic [31:0] hold_a;
  logic [31:0] hold_d;
  int n;

  initial begin
    exp_addr     = BASE;
    exp_ww       = 16'd0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    im_ready     = 1'b0;
    instrCode_in = 6'd0;
    rs_in        = 5'd0;
    rt_in        = 5'd0;
    rd_in        = 5'd0;
    shamt_in     = 5'd0;
    imm_in       = 16'd0;
    target_in    = 26'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_im_we", {31'd0, im_we}, 32'd0);
    chk("rst_im_addr", im_addr, BASE);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_ww", {16'd0, words_written}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;

    // Single addu, first-word latency.
    im_ready = 1'b1;
    push(C_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    @(negedge clk);
    chk("t1_we", {31'd0, im_we}, 32'd1);
    chk("t1_addr", im_addr, 32'h0000_3000);
    chk("t1_wdata", im_wdata, 32'h0022_1821);
    @(negedge clk);
    chk("t1_ww", {16'd0, words_written}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back stream; sll rs garbage must be dropped.
    push(C_ORI, 5'd0, 5'd1, 5'd9, 5'd3, 16'h1234, 26'd5);
    push(C_LUI, 5'd9, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'd0);
    push(C_SLL, 5'd7, 5'd3, 5'd2, 5'd4, 16'hAAAA, 26'd0);
    push(C_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0);
    drain();
    chk("t2_addr_end", im_addr, 32'h0000_3014);

    // Stall: fill the FIFO with im_ready low.
    im_ready = 1'b0;
    push(C_SUBU, 5'd4, 5'd5, 5'd6, 5'd1, 16'd1, 26'd1);
    push(C_ANDI, 5'd8, 5'd9, 5'd0, 5'd0, 16'h00F0, 26'd0);
    push(C_LW, 5'd29, 5'd10, 5'd0, 5'd0, 16'h8004, 26'd0);
    push(C_SW, 5'd29, 5'd11, 5'd0, 5'd0, 16'h0008, 26'd0);
    drive(C_JR, 5'd31, 5'd3, 5'd3, 5'd3, 16'hFFFF, 26'd7);
    @(negedge clk);
    chk("t3_full", {31'd0, in_ready}, 32'd0);
    chk("t3_head_addr", im_addr, 32'h0000_3014);
    chk("t3_head_data", im_wdata, 32'h0085_3023);
    hold_a = im_addr;
    hold_d = im_wdata;
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_rdy", {31'd0, in_ready}, 32'd0);
      chk("t3_hold_we", {31'd0, im_we}, 32'd1);
      chk("t3_hold_addr", im_addr, hold_a);
      chk("t3_hold_data", im_wdata, hold_d);
    end
    @(posedge clk);
    #1;
    im_ready = 1'b1;
    commit();
    drain();
    chk("t3_ready_back", {31'd0, in_ready}, 32'd1);
    chk("t3_ww", {16'd0, words_written}, 32'd10);

    // Jumps.
    push(C_J, 5'd1, 5'd1, 5'd1, 5'd1, 16'd1, 26'h0000C00);
    push(C_JAL, 5'd2, 5'd2, 5'd2, 5'd2, 16'd2, 26'h0100000);
    drain();

    // Unknown code between two valid ones.
    chk("t5_err_pre", {31'd0, err}, 32'd0);
    push(C_ADDU, 5'd3, 5'd4, 5'd5, 5'd0, 16'd0, 26'd0);
    push(6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'd9);
    push(C_ORI, 5'd6, 5'd7, 5'd0, 5'd0, 16'hBEEF, 26'd0);
    drain();
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_ww", {16'd0, words_written}, 32'd14);
    chk("t5_addr", im_addr, 32'h0000_3038);

    // Reset with three words pending; reset cycle must not pop.
    im_ready = 1'b0;
    push(C_SUBU, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
    push(C_LW, 5'd2, 5'd2, 5'd0, 5'd0, 16'd4, 26'd0);
    push(C_SW, 5'd3, 5'd3, 5'd0, 5'd0, 16'd8, 26'd0);
    @(negedge clk);
    chk("t6_we_pre", {31'd0, im_we}, 32'd1);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    im_ready = 1'b1;
    sbq.delete();
    exp_addr = BASE;
    exp_ww   = 16'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_we", {31'd0, im_we}, 32'd0);
    chk("t6_addr", im_addr, BASE);
    chk("t6_ww", {16'd0, words_written}, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);

    // Operation resumes cleanly after reset.
    @(posedge clk);
    #1;
    push(C_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF);
    drain();
    chk("t7_addr", im_addr, 32'h0000_3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
